// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, operand-buffer state encoding and burst default for the register-file port scheduler
package rf_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WR_BURST_MAX_DEF = 4;
  typedef enum logic {OB_EMPTY, OB_FULL} ob_state_t;
endpackage

// File: rtl/rf_op_buf.sv
// rf_op_buf: single-entry operand buffer between the register file and execute
// Ports:
//   clk, reset (async, active-low)
//   load            - capture d_rs1/d_rs2 this cycle (a read was granted)
//   op_ready        - execute consumes the buffered operands
//   d_rs1, d_rs2    - operand data to capture
//   op_valid        - buffer holds operands (state FULL)
//   op_rs1, op_rs2  - buffered operands, held while op_valid && !op_ready
module rf_op_buf
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            op_ready,
  input  logic [XLEN-1:0] d_rs1,
  input  logic [XLEN-1:0] d_rs2,
  output logic            op_valid,
  output logic [XLEN-1:0] op_rs1,
  output logic [XLEN-1:0] op_rs2
);
  ob_state_t state, state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= OB_EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_rs1 <= '0;
      op_rs2 <= '0;
    end else if (load) begin
      op_rs1 <= d_rs1;
      op_rs2 <= d_rs2;
    end
  // A load is only offered when EMPTY or FULL-and-draining, so it always lands in FULL.
  always_comb begin
    state_nxt = state;
    state_nxt = load ? OB_FULL : (state == OB_FULL && op_ready) ? OB_EMPTY : state;
  end
  assign op_valid = state == OB_FULL;
endmodule

// File: rtl/rf_port_sched.sv
// rf_port_sched: arbitrates one register-file port between writeback and decode operand reads
// Ports:
//   clk, reset (async, active-low)
//   dec_*    - decode operand-read request (valid/ready, source addresses, source-use flags)
//   wb_*     - writeback request (valid/ready, destination, data)
//   rs1_addr, rs2_addr, read_rs1, read_rs2, rs1, rs2 - register-file read side
//   rd, rd_data, rd_write                            - register-file write side
//   op_valid, op_ready, op_rs1, op_rs2               - operands to execute
// Parameter WR_BURST_MAX: consecutive write grants tolerated while a grantable read waits.
// Optional macro RF_BYPASS_EN: a read whose used sources all match the write destination
// completes in the write cycle, taking wb_data directly.
module rf_port_sched
  import rf_pkg::*;
#(
  parameter int WR_BURST_MAX = WR_BURST_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic signed [XLEN-1:0] wb_data,
  output logic [XLEN-1:0]       rs1_addr,
  output logic [XLEN-1:0]       rs2_addr,
  output logic [XLEN-1:0]       rd,
  output logic signed [XLEN-1:0] rd_data,
  output logic                  rd_write,
  output logic                  read_rs1,
  output logic                  read_rs2,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [XLEN-1:0]       op_rs1,
  output logic [XLEN-1:0]       op_rs2
);
  localparam logic [3:0] BMAX = 4'(WR_BURST_MAX);
  logic [3:0] burst_cnt;
  logic gok, rd_pend, starve, wr_gnt, rd_gnt, byp, load;
  logic [XLEN-1:0] d_rs1, d_rs2;
  // Reset gates every grant so requesters see ready low for the whole reset.
  assign gok = !op_valid || op_ready;
  assign rd_pend = reset && dec_valid && gok;
  assign starve = rd_pend && burst_cnt == BMAX;
  assign wr_gnt = reset && wb_valid && !starve;
  assign rd_gnt = rd_pend && !wr_gnt;
`ifdef RF_BYPASS_EN
  assign byp = wr_gnt && rd_pend && wb_rd != '0 &&
               (!dec_use_rs1 || dec_rs1_addr == wb_rd) &&
               (!dec_use_rs2 || dec_rs2_addr == wb_rd);
  assign d_rs1 = !dec_use_rs1 ? '0 : byp ? wb_data : rs1;
  assign d_rs2 = !dec_use_rs2 ? '0 : byp ? wb_data : rs2;
`else
  assign byp = 1'b0;
  assign d_rs1 = dec_use_rs1 ? rs1 : '0;
  assign d_rs2 = dec_use_rs2 ? rs2 : '0;
`endif
  assign load = rd_gnt || byp;
  always_comb begin
    dec_ready = load;
    wb_ready  = wr_gnt;
    read_rs1  = rd_gnt && dec_use_rs1;
    read_rs2  = rd_gnt && dec_use_rs2;
    rs1_addr  = rd_gnt ? XLEN'(dec_rs1_addr) : '0;
    rs2_addr  = rd_gnt ? XLEN'(dec_rs2_addr) : '0;
    rd        = wr_gnt ? XLEN'(wb_rd) : '0;
    rd_data   = wr_gnt ? wb_data : '0;
    rd_write  = wr_gnt && wb_rd != '0;
  end
  // Counts writes that overtook a grantable read; reaching BMAX hands the next slot to the read.
  always_ff @(posedge clk or negedge reset)
    if (!reset) burst_cnt <= '0;
    else if (!dec_valid || dec_ready) burst_cnt <= '0;
    else if (wr_gnt && rd_pend && burst_cnt != BMAX) burst_cnt <= burst_cnt + 4'd1;
  rf_op_buf u_op_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .op_ready (op_ready),
    .d_rs1    (d_rs1),
    .d_rs2    (d_rs2),
    .op_valid (op_valid),
    .op_rs1   (op_rs1),
    .op_rs2   (op_rs2)
  );
endmodule

// File: tb/tb_rf_port_sched.sv
// tb_rf_port_sched: directed table, corner sequences and randomized model check for rf_port_sched
module tb_rf_port_sched;
  localparam int BM = 4;
  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_ready, dec_use_rs1, dec_use_rs2;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, wb_rd;
  logic wb_valid, wb_ready;
  logic signed [31:0] wb_data, rd_data;
  logic [31:0] rs1_addr, rs2_addr, rd, rs1, rs2, op_rs1, op_rs2;
  logic rd_write, read_rs1, read_rs2, op_valid, op_ready;
  logic [31:0] regs [32];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign rs1 = regs[rs1_addr[4:0]];
  assign rs2 = regs[rs2_addr[4:0]];

  rf_port_sched #(.WR_BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd(rd), .rd_data(rd_data),
    .rd_write(rd_write), .read_rs1(read_rs1), .read_rs2(read_rs2),
    .rs1(rs1), .rs2(rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1(op_rs1), .op_rs2(op_rs2)
  );

  typedef struct {
    logic wv; logic [4:0] wrd; logic [31:0] wdata;
    logic dv; logic [4:0] a1, a2; logic u1, u2, ordy;
    logic e_wbr, e_decr, e_rdw, e_opv; logic [31:0] e_op1, e_op2;
  } vec_t;
  vec_t tv[$];

  // behavioural model state
  logic m_full;
  logic [31:0] m_op1, m_op2;
  int m_cnt;
  logic [31:0] m_regs [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [4:0] wrd, input int wdata,
                     input logic dv, input logic [4:0] a1, input logic [4:0] a2,
                     input logic u1, input logic u2, input logic ordy,
                     input logic e_wbr, input logic e_decr, input logic e_rdw,
                     input logic e_opv, input int e_op1, input int e_op2);
    vec_t v;
    v.wv = wv; v.wrd = wrd; v.wdata = wdata; v.dv = dv; v.a1 = a1; v.a2 = a2;
    v.u1 = u1; v.u2 = u2; v.ordy = ordy; v.e_wbr = e_wbr; v.e_decr = e_decr;
    v.e_rdw = e_rdw; v.e_opv = e_opv; v.e_op1 = e_op1; v.e_op2 = e_op2;
    tv.push_back(v);
  endtask

  task automatic apply(input logic wv, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic dv, input logic [4:0] a1, input logic [4:0] a2,
                       input logic u1, input logic u2, input logic ordy);
    wb_valid = wv; wb_rd = wrd; wb_data = wdata;
    dec_valid = dv; dec_rs1_addr = a1; dec_rs2_addr = a2;
    dec_use_rs1 = u1; dec_use_rs2 = u2; op_ready = ordy;
  endtask

  // the register file behind the port: commit what the DUT writes, then move to the next cycle
  task automatic tick();
    if (rd_write) regs[rd[4:0]] = rd_data;
    @(posedge clk);
    #1;
  endtask

  task automatic init_regs();
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'd0 : 32'(i * 7 - 50);
      m_regs[i] = regs[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply(1'b1, 5'd3, 32'd1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    #3;
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_rs1", op_rs1, 32'd0);
    chk("rst_rd_write", {31'd0, rd_write}, 32'd0);
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    m_full = 1'b0; m_op1 = '0; m_op2 = '0; m_cnt = 0;
  endtask

  // Reference cycle: write wins unless a grantable read has already been overtaken BM times.
  task automatic model_cycle();
    logic gok, rpend, wgnt, rgnt, byp;
    logic [31:0] n1, n2;
    gok = !m_full || op_ready;
    rpend = dec_valid && gok;
    wgnt = wb_valid && !(rpend && m_cnt == BM);
    rgnt = rpend && !wgnt;
    byp = 1'b0;
`ifdef RF_BYPASS_EN
    byp = wgnt && rpend && wb_rd != 0 && (!dec_use_rs1 || dec_rs1_addr == wb_rd) &&
          (!dec_use_rs2 || dec_rs2_addr == wb_rd);
`endif
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, wgnt});
    chk("dec_ready", {31'd0, dec_ready}, {31'd0, rgnt || byp});
    chk("rd_write", {31'd0, rd_write}, {31'd0, wgnt && wb_rd != 0});
    chk("rd", rd, wgnt ? {27'd0, wb_rd} : 32'd0);
    chk("rd_data", rd_data, wgnt ? wb_data : 32'd0);
    chk("read_rs1", {31'd0, read_rs1}, {31'd0, rgnt && dec_use_rs1});
    chk("read_rs2", {31'd0, read_rs2}, {31'd0, rgnt && dec_use_rs2});
    chk("rs1_addr", rs1_addr, rgnt ? {27'd0, dec_rs1_addr} : 32'd0);
    chk("rs2_addr", rs2_addr, rgnt ? {27'd0, dec_rs2_addr} : 32'd0);
    chk("op_valid", {31'd0, op_valid}, {31'd0, m_full});
    if (m_full) begin
      chk("op_rs1", op_rs1, m_op1);
      chk("op_rs2", op_rs2, m_op2);
    end
    n1 = !dec_use_rs1 ? 32'd0 : byp ? wb_data : m_regs[dec_rs1_addr];
    n2 = !dec_use_rs2 ? 32'd0 : byp ? wb_data : m_regs[dec_rs2_addr];
    if (rgnt || byp) begin
      m_full = 1'b1; m_op1 = n1; m_op2 = n2;
    end else if (m_full && op_ready) m_full = 1'b0;
    if (!dec_valid || rgnt || byp) m_cnt = 0;
    else if (wgnt && rpend && m_cnt < BM) m_cnt++;
    if (wgnt && wb_rd != 0) m_regs[wb_rd] = wb_data;
  endtask

  initial begin
    init_regs();
    do_reset();
    //  wv wrd  wdata  dv a1 a2 u1 u2 ordy | wbr decr rdw opv op1 op2
    add(1, 5,   -7,    0, 0, 0, 0, 0, 1,    1,  0,   1,  0,  0,  0);
    add(1, 6,    3,    0, 0, 0, 0, 0, 1,    1,  0,   1,  0,  0,  0);
    add(1, 0,   55,    0, 0, 0, 0, 0, 1,    1,  0,   0,  0,  0,  0);
    add(0, 0,    0,    1, 5, 6, 1, 1, 0,    0,  1,   0,  0,  0,  0);
    add(0, 0,    0,    1, 6, 5, 1, 1, 0,    0,  0,   0,  1, -7,  3);
    add(0, 0,    0,    1, 6, 5, 1, 1, 0,    0,  0,   0,  1, -7,  3);
    add(0, 0,    0,    1, 6, 5, 1, 1, 1,    0,  1,   0,  1, -7,  3);
    add(0, 0,    0,    0, 0, 0, 0, 0, 0,    0,  0,   0,  1,  3, -7);
    add(0, 0,    0,    1, 5, 9, 1, 0, 1,    0,  1,   0,  1,  3, -7);
    add(0, 0,    0,    0, 0, 0, 0, 0, 1,    0,  0,   0,  1, -7,  0);
    add(0, 0,    0,    0, 0, 0, 0, 0, 1,    0,  0,   0,  0,  0,  0);
    add(1, 7,    1,    1, 5, 6, 1, 1, 1,    1,  0,   1,  0,  0,  0);
    foreach (tv[i]) begin
      apply(tv[i].wv, tv[i].wrd, tv[i].wdata, tv[i].dv, tv[i].a1, tv[i].a2,
            tv[i].u1, tv[i].u2, tv[i].ordy);
      #3;
      chk($sformatf("v%0d_wb_ready", i), {31'd0, wb_ready}, {31'd0, tv[i].e_wbr});
      chk($sformatf("v%0d_dec_ready", i), {31'd0, dec_ready}, {31'd0, tv[i].e_decr});
      chk($sformatf("v%0d_rd_write", i), {31'd0, rd_write}, {31'd0, tv[i].e_rdw});
      chk($sformatf("v%0d_rd_data", i), rd_data, tv[i].e_wbr ? tv[i].wdata : 32'd0);
      chk($sformatf("v%0d_op_valid", i), {31'd0, op_valid}, {31'd0, tv[i].e_opv});
      if (tv[i].e_wbr) begin
        chk($sformatf("v%0d_rd", i), rd, {27'd0, tv[i].wrd});
        chk($sformatf("v%0d_no_read", i), {30'd0, read_rs1, read_rs2}, 32'd0);
      end
      if (tv[i].e_opv) begin
        chk($sformatf("v%0d_op_rs1", i), op_rs1, tv[i].e_op1);
        chk($sformatf("v%0d_op_rs2", i), op_rs2, tv[i].e_op2);
      end
      tick();
    end

    // starvation: a held write stream yields every (BM+1)th slot to the waiting read
    do_reset();
    apply(1'b1, 5'd9, 32'd100, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3 * (BM + 1); i++) begin
      #3;
      chk($sformatf("starve%0d_wb_ready", i), {31'd0, wb_ready}, {31'd0, (i % (BM + 1)) != BM});
      chk($sformatf("starve%0d_dec_ready", i), {31'd0, dec_ready}, {31'd0, (i % (BM + 1)) == BM});
      tick();
    end

    // reset while FULL and stalled: outputs drop without a clock edge
    do_reset();
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    apply(1'b1, 5'd9, 32'd4, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    chk("pre_rst_op_valid", {31'd0, op_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_op_valid", {31'd0, op_valid}, 32'd0);
    chk("async_op_rs1", op_rs1, 32'd0);
    chk("async_ctrl", {27'd0, dec_ready, wb_ready, rd_write, read_rs1, read_rs2}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_ctrl", {27'd0, dec_ready, wb_ready, rd_write, read_rs1, read_rs2}, 32'd0);

    // randomized traffic against the reference model
    init_regs();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      apply($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), $urandom_range(0, 9) < 6);
      #3;
      model_cycle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
